// File: rtl/lpif_dstrm_pkg.sv
// Shared types and constants for the LPIF downstream receive buffer.
// Entry layout, link-state encodings and a depth-to-pointer-width helper.
package lpif_dstrm_pkg;

  typedef struct packed {
    logic [1:0]   protid;
    logic         crc_valid;
    logic [7:0]   crc;
    logic [127:0] data;
  } lpif_dstrm_entry_t;

  localparam logic [3:0] LPIF_ST_RESET   = 4'h0;
  localparam logic [3:0] LPIF_ST_ACTIVE  = 4'h1;
  localparam logic [3:0] LPIF_ST_RETRAIN = 4'hB;
  localparam logic [3:0] LPIF_ST_LINKERR = 4'hA;

  // Pointer width for a power-of-two depth (ceil log2).
  function automatic int clog2_depth(input int depth);
    int r;
    r = 0;
    while ((1 << r) < depth) r++;
    return r;
  endfunction

endpackage

// File: rtl/lpif_dstrm_sync_fifo.sv
// Generic single-clock first-word-fall-through FIFO with separate occupancy count.
// Read data is forced to zero while empty so the head never shows stale storage.
module lpif_dstrm_sync_fifo
  import lpif_dstrm_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 139,
  parameter int PTR_W = clog2_depth(DEPTH),
  parameter int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty,
  output logic             push_ok,
  output logic             pop_ok
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [LVL_W-1:0] level_reg;
  logic [LVL_W-1:0] level_next;
  logic [WIDTH-1:0] rd_raw;

  assign empty = (level_reg == '0);
  assign full  = (level_reg == LVL_W'(DEPTH));
  assign level = level_reg;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
  assign pop_ok  = pop & ~empty & ~flush;
  assign push_ok = push & ~flush & (~full | pop_ok);

  always_comb begin
    level_next = level_reg + LVL_W'(push_ok) - LVL_W'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      level_reg <= level_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_reg[wr_ptr_reg] <= wr_data;
  end

  assign rd_raw = mem_reg[rd_ptr_reg];

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rd_gate
      assign rd_data[gi] = rd_raw[gi] & ~empty;
    end
  endgenerate

endmodule

// File: rtl/lpif_dstrm_rx_buffer.sv
// LPIF downstream receive buffer: FIFO, per-pop credit return, link-state capture, overflow flag.
// Define LPIF_DSTRM_RX_STATS_EN to add saturating stat_beats / stat_drops counters.
module lpif_dstrm_rx_buffer
  import lpif_dstrm_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int DATA_WIDTH   = 128,
  parameter int CRC_WIDTH    = 8,
  parameter int PROTID_WIDTH = 2,
  parameter int STATE_WIDTH  = 4
) (
  input  logic                        clk_wr,
  input  logic                        rst_wr_n,
  input  logic                        rx_online,
  input  logic [STATE_WIDTH-1:0]      dstrm_state,
  input  logic [PROTID_WIDTH-1:0]     dstrm_protid,
  input  logic [DATA_WIDTH-1:0]       dstrm_data,
  input  logic                        dstrm_dvalid,
  input  logic [CRC_WIDTH-1:0]        dstrm_crc,
  input  logic                        dstrm_crc_valid,
  input  logic                        dstrm_valid,
  output logic [DATA_WIDTH-1:0]       pl_data,
  output logic [PROTID_WIDTH-1:0]     pl_protid,
  output logic [CRC_WIDTH-1:0]        pl_crc,
  output logic                        pl_crc_valid,
  output logic                        pl_valid,
  input  logic                        pl_ready,
  output logic [STATE_WIDTH-1:0]      pl_state,
  output logic                        pl_state_chg,
  output logic                        credit_return,
  output logic [clog2_depth(DEPTH):0] fifo_level,
`ifdef LPIF_DSTRM_RX_STATS_EN
  output logic [31:0]                 stat_beats,
  output logic [15:0]                 stat_drops,
`endif
  output logic                        overflow_sticky
);

  localparam int PTR_W   = clog2_depth(DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int ENTRY_W = PROTID_WIDTH + 1 + CRC_WIDTH + DATA_WIDTH;

  logic [ENTRY_W-1:0]     wr_entry;
  logic [ENTRY_W-1:0]     rd_entry;
  logic [LVL_W-1:0]       level;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   push_req;
  logic                   push_ok;
  logic                   pop_ok;
  logic                   drop_evt;
  logic                   state_upd;

  logic                   credit_return_reg;
  logic [STATE_WIDTH-1:0] pl_state_reg;
  logic                   pl_state_chg_reg;
  logic                   overflow_sticky_reg;

  assign push_req = rx_online & dstrm_valid & dstrm_dvalid;
  assign wr_entry = {dstrm_protid, dstrm_crc_valid, dstrm_crc, dstrm_data};

  lpif_dstrm_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .PTR_W (PTR_W),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk     (clk_wr),
    .rst_n   (rst_wr_n),
    .flush   (~rx_online),
    .push    (push_req),
    .pop     (pl_ready),
    .wr_data (wr_entry),
    .rd_data (rd_entry),
    .level   (level),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .push_ok (push_ok),
    .pop_ok  (pop_ok)
  );

  assign {pl_protid, pl_crc_valid, pl_crc, pl_data} = rd_entry;
  assign pl_valid   = ~fifo_empty;
  assign fifo_level = level;

  // Pushes only happen while online, so a drop never coincides with a flush.
  assign drop_evt  = push_req & fifo_full & ~pop_ok;
  assign state_upd = rx_online & dstrm_valid & (dstrm_state != pl_state_reg);

  always_ff @(posedge clk_wr) begin
    if (!rst_wr_n) begin
      credit_return_reg   <= 1'b0;
      pl_state_reg        <= '0;
      pl_state_chg_reg    <= 1'b0;
      overflow_sticky_reg <= 1'b0;
    end else begin
      credit_return_reg <= pop_ok;
      pl_state_chg_reg  <= state_upd;
      if (state_upd) pl_state_reg <= dstrm_state;
      if (drop_evt)  overflow_sticky_reg <= 1'b1;
    end
  end

  assign credit_return   = credit_return_reg;
  assign pl_state        = pl_state_reg;
  assign pl_state_chg    = pl_state_chg_reg;
  assign overflow_sticky = overflow_sticky_reg;

`ifdef LPIF_DSTRM_RX_STATS_EN
  logic [31:0] stat_beats_reg;
  logic [15:0] stat_drops_reg;

  always_ff @(posedge clk_wr) begin
    if (!rst_wr_n) begin
      stat_beats_reg <= '0;
      stat_drops_reg <= '0;
    end else begin
      if (push_ok && (stat_beats_reg != '1))  stat_beats_reg <= stat_beats_reg + 32'd1;
      if (drop_evt && (stat_drops_reg != '1)) stat_drops_reg <= stat_drops_reg + 16'd1;
    end
  end

  assign stat_beats = stat_beats_reg;
  assign stat_drops = stat_drops_reg;
`endif

endmodule

// File: tb/tb_lpif_dstrm_rx_buffer.sv
// Self-checking bench for lpif_dstrm_rx_buffer: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_lpif_dstrm_rx_buffer;
  import lpif_dstrm_pkg::*;

  localparam int DEPTH = 8;
  localparam int LVL_W = 4;

  logic         clk_wr = 1'b0;
  logic         rst_wr_n;
  logic         rx_online;
  logic [3:0]   dstrm_state;
  logic [1:0]   dstrm_protid;
  logic [127:0] dstrm_data;
  logic         dstrm_dvalid;
  logic [7:0]   dstrm_crc;
  logic         dstrm_crc_valid;
  logic         dstrm_valid;
  logic [127:0] pl_data;
  logic [1:0]   pl_protid;
  logic [7:0]   pl_crc;
  logic         pl_crc_valid;
  logic         pl_valid;
  logic         pl_ready;
  logic [3:0]   pl_state;
  logic         pl_state_chg;
  logic         credit_return;
  logic [LVL_W-1:0] fifo_level;
  logic         overflow_sticky;
`ifdef LPIF_DSTRM_RX_STATS_EN
  logic [31:0]  stat_beats;
  logic [15:0]  stat_drops;
`endif

  always #5 clk_wr = ~clk_wr;

  lpif_dstrm_rx_buffer dut (
    .clk_wr          (clk_wr),
    .rst_wr_n        (rst_wr_n),
    .rx_online       (rx_online),
    .dstrm_state     (dstrm_state),
    .dstrm_protid    (dstrm_protid),
    .dstrm_data      (dstrm_data),
    .dstrm_dvalid    (dstrm_dvalid),
    .dstrm_crc       (dstrm_crc),
    .dstrm_crc_valid (dstrm_crc_valid),
    .dstrm_valid     (dstrm_valid),
    .pl_data         (pl_data),
    .pl_protid       (pl_protid),
    .pl_crc          (pl_crc),
    .pl_crc_valid    (pl_crc_valid),
    .pl_valid        (pl_valid),
    .pl_ready        (pl_ready),
    .pl_state        (pl_state),
    .pl_state_chg    (pl_state_chg),
    .credit_return   (credit_return),
    .fifo_level      (fifo_level),
`ifdef LPIF_DSTRM_RX_STATS_EN
    .stat_beats      (stat_beats),
    .stat_drops      (stat_drops),
`endif
    .overflow_sticky (overflow_sticky)
  );

  // Reference model: the buffer is just an ordered list of accepted beats.
  lpif_dstrm_entry_t q[$];
  bit          m_ovf;
  logic [3:0]  m_state;
  bit          m_chg;
  bit          m_credit;
  int unsigned m_beats;
  int unsigned m_drops;

  int checks = 0;
  int errors = 0;

  function automatic lpif_dstrm_entry_t exp_head();
    if (q.size() == 0) return '0;
    return q[0];
  endfunction

  task automatic set_in(input bit online, input bit valid, input bit dvalid,
                        input logic [3:0] st, input logic [127:0] data, input bit ready);
    rx_online       = online;
    dstrm_valid     = valid;
    dstrm_dvalid    = dvalid;
    dstrm_state     = st;
    dstrm_data      = data;
    dstrm_protid    = 2'($urandom);
    dstrm_crc       = 8'($urandom);
    dstrm_crc_valid = 1'($urandom);
    pl_ready        = ready;
  endtask

  // Advance the model by one clock using the currently driven inputs, then sample point.
  task automatic step();
    lpif_dstrm_entry_t e;
    bit pop, push;
    if (!rst_wr_n) begin
      q.delete();
      m_ovf = 0; m_state = '0; m_chg = 0; m_credit = 0; m_beats = 0; m_drops = 0;
    end else begin
      pop  = rx_online && (q.size() > 0) && pl_ready;
      push = rx_online && dstrm_valid && dstrm_dvalid;
      m_credit = pop;
      m_chg = rx_online && dstrm_valid && (dstrm_state != m_state);
      if (m_chg) m_state = dstrm_state;
      if (!rx_online) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (push) begin
          if (q.size() < DEPTH) begin
            e.protid = dstrm_protid; e.crc_valid = dstrm_crc_valid;
            e.crc = dstrm_crc; e.data = dstrm_data;
            q.push_back(e);
            if (m_beats != 32'hFFFF_FFFF) m_beats++;
          end else begin
            m_ovf = 1;
            if (m_drops != 16'hFFFF) m_drops++;
          end
        end
      end
    end
    @(posedge clk_wr);
    #1;
  endtask

  task automatic test_reset();
    rst_wr_n = 1'b0;
    set_in(1, 1, 1, LPIF_ST_ACTIVE, 128'h55, 1);
    step();
    step();
    checks++; if (pl_valid !== 1'b0) begin errors++; $display("FAIL reset_pl_valid got=%0b exp=0", pl_valid); end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    checks++; if ({pl_protid, pl_crc_valid, pl_crc, pl_data} !== '0) begin errors++; $display("FAIL reset_pl_data got=%h exp=0", pl_data); end
    checks++; if ({pl_state, pl_state_chg, credit_return, overflow_sticky} !== 7'd0) begin
      errors++; $display("FAIL reset_misc got state=%h chg=%0b credit=%0b ovf=%0b exp all 0", pl_state, pl_state_chg, credit_return, overflow_sticky);
    end
`ifdef LPIF_DSTRM_RX_STATS_EN
    checks++; if ({stat_beats, stat_drops} !== 48'd0) begin errors++; $display("FAIL reset_stats got beats=%0d drops=%0d exp 0", stat_beats, stat_drops); end
`endif
    rst_wr_n = 1'b1;
    set_in(1, 0, 0, LPIF_ST_RESET, '0, 0);
    step();
    $display("test_reset: done");
  endtask

  task automatic test_basic_order();
    for (int i = 1; i <= 3; i++) begin
      set_in(1, 1, 1, LPIF_ST_RESET, 128'(i), 0);
      step();
    end
    set_in(1, 0, 0, LPIF_ST_RESET, '0, 0);
    step();
    checks++; if (fifo_level !== LVL_W'(3)) begin errors++; $display("FAIL basic_level got=%0d exp=3", fifo_level); end
    checks++; if (pl_data !== 128'h1) begin errors++; $display("FAIL basic_hold got=%h exp=1", pl_data); end
    for (int i = 1; i <= 3; i++) begin
      checks++; if (pl_data !== 128'(i)) begin errors++; $display("FAIL basic_order got=%h exp=%h", pl_data, 128'(i)); end
      set_in(1, 0, 0, LPIF_ST_RESET, '0, 1);
      step();
      checks++; if (credit_return !== 1'b1) begin errors++; $display("FAIL basic_credit got=%0b exp=1", credit_return); end
      $display("basic: popped beat %0d, credit=%0b level=%0d", i, credit_return, fifo_level);
    end
    step();
    checks++; if ({credit_return, pl_valid} !== 2'b00) begin errors++; $display("FAIL basic_empty got credit=%0b valid=%0b exp 0 0", credit_return, pl_valid); end
  endtask

  task automatic drain(input string tag);
    lpif_dstrm_entry_t e;
    for (int n = 0; n < 2 * DEPTH && pl_valid; n++) begin
      e = exp_head();
      checks++; if ({pl_protid, pl_crc_valid, pl_crc, pl_data} !== e) begin
        errors++; $display("FAIL %s_drain got=%h exp=%h", tag, pl_data, e.data);
      end
      set_in(1, 0, 0, m_state, '0, 1);
      step();
      $display("%s: drained beat, level=%0d", tag, fifo_level);
    end
    checks++; if (pl_valid !== 1'b0 || q.size() != 0) begin errors++; $display("FAIL %s_drain_end got valid=%0b exp=0", tag, pl_valid); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1, 1, 1, LPIF_ST_RESET, 128'h100 + 128'(i), 0);
      step();
    end
    set_in(1, 1, 1, LPIF_ST_RESET, 128'hAA, 1);
    step();
    checks++; if (fifo_level !== LVL_W'(DEPTH)) begin errors++; $display("FAIL fullpp_level got=%0d exp=%0d", fifo_level, DEPTH); end
    checks++; if (overflow_sticky !== 1'b0) begin errors++; $display("FAIL fullpp_ovf got=%0b exp=0", overflow_sticky); end
    checks++; if (q[DEPTH-1].data !== 128'hAA) begin errors++; $display("FAIL fullpp_model_tail got=%h exp=aa", q[DEPTH-1].data); end
    drain("fullpp");
  endtask

  task automatic test_overflow();
    for (int i = 0; i <= DEPTH; i++) begin
      set_in(1, 1, 1, LPIF_ST_RESET, 128'h10 + 128'(i), 0);
      step();
    end
    checks++; if (fifo_level !== LVL_W'(DEPTH)) begin errors++; $display("FAIL ovf_level got=%0d exp=%0d", fifo_level, DEPTH); end
    checks++; if (overflow_sticky !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%0b exp=1", overflow_sticky); end
`ifdef LPIF_DSTRM_RX_STATS_EN
    checks++; if (stat_drops !== 16'd1) begin errors++; $display("FAIL ovf_stat_drops got=%0d exp=1", stat_drops); end
`endif
    drain("ovf");
  endtask

  task automatic test_state();
    logic [3:0] seq [4];
    int pulses;
    seq[0] = LPIF_ST_RESET; seq[1] = LPIF_ST_ACTIVE; seq[2] = LPIF_ST_ACTIVE; seq[3] = LPIF_ST_RETRAIN;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      set_in(1, 1, 0, seq[i], 128'hDEAD, 0);
      step();
      if (pl_state_chg === 1'b1) pulses++;
      $display("state: drove %h, pl_state=%h chg=%0b", seq[i], pl_state, pl_state_chg);
    end
    set_in(1, 0, 0, LPIF_ST_RETRAIN, '0, 0);
    step();
    if (pl_state_chg === 1'b1) pulses++;
    checks++; if (pulses != 2) begin errors++; $display("FAIL state_pulses got=%0d exp=2", pulses); end
    checks++; if (pl_state !== LPIF_ST_RETRAIN) begin errors++; $display("FAIL state_value got=%h exp=b", pl_state); end
    checks++; if (fifo_level !== '0) begin errors++; $display("FAIL state_level got=%0d exp=0", fifo_level); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) begin
      set_in(1, 1, 1, LPIF_ST_RETRAIN, 128'h200 + 128'(i), 0);
      step();
    end
    set_in(0, 1, 1, LPIF_ST_LINKERR, 128'h999, 0);
    step();
    checks++; if ({pl_valid, fifo_level} !== '0) begin errors++; $display("FAIL flush_empty got valid=%0b level=%0d exp 0 0", pl_valid, fifo_level); end
    checks++; if (credit_return !== 1'b0) begin errors++; $display("FAIL flush_credit got=%0b exp=0", credit_return); end
    checks++; if (pl_state !== LPIF_ST_RETRAIN) begin errors++; $display("FAIL flush_state got=%h exp=b", pl_state); end
    checks++; if (overflow_sticky !== 1'b1) begin errors++; $display("FAIL flush_ovf_held got=%0b exp=1", overflow_sticky); end
    set_in(1, 0, 0, LPIF_ST_RETRAIN, '0, 1);
    step();
    checks++; if ({credit_return, pl_valid} !== 2'b00) begin errors++; $display("FAIL flush_after got credit=%0b valid=%0b exp 0 0", credit_return, pl_valid); end
    $display("flush: level=%0d state=%h", fifo_level, pl_state);
  endtask

  task automatic test_random();
    lpif_dstrm_entry_t e;
    logic [3:0] st;
    logic [3:0] st_tab [4];
    st_tab[0] = LPIF_ST_RESET; st_tab[1] = LPIF_ST_ACTIVE; st_tab[2] = LPIF_ST_RETRAIN; st_tab[3] = LPIF_ST_LINKERR;
    st = m_state;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(9) == 0) st = st_tab[$urandom_range(3)];
      set_in($urandom_range(19) != 0, $urandom_range(9) < 7, $urandom_range(9) < 8, st,
             {$urandom, $urandom, $urandom, $urandom}, $urandom_range(9) < 4);
      step();
      e = exp_head();
      checks++; if ({pl_protid, pl_crc_valid, pl_crc, pl_data} !== e) begin errors++; $display("FAIL rand_head c=%0d got=%h exp=%h", c, pl_data, e.data); end
      checks++; if (pl_valid !== (q.size() != 0) || fifo_level !== LVL_W'(q.size())) begin
        errors++; $display("FAIL rand_level c=%0d got valid=%0b level=%0d exp level=%0d", c, pl_valid, fifo_level, q.size());
      end
      checks++; if ({credit_return, pl_state_chg, pl_state, overflow_sticky} !== {m_credit, m_chg, m_state, m_ovf}) begin
        errors++; $display("FAIL rand_ctrl c=%0d got credit=%0b chg=%0b state=%h ovf=%0b exp %0b %0b %h %0b",
                           c, credit_return, pl_state_chg, pl_state, overflow_sticky, m_credit, m_chg, m_state, m_ovf);
      end
`ifdef LPIF_DSTRM_RX_STATS_EN
      checks++; if (stat_beats !== m_beats || stat_drops !== 16'(m_drops)) begin
        errors++; $display("FAIL rand_stats c=%0d got beats=%0d drops=%0d exp %0d %0d", c, stat_beats, stat_drops, m_beats, m_drops);
      end
`endif
      if (c % 50 == 0) $display("random: cycle %0d level=%0d credit=%0b", c, fifo_level, credit_return);
    end
  endtask

  task automatic test_reset_mid();
    set_in(0, 0, 0, m_state, '0, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      set_in(1, 1, 1, m_state, 128'h300 + 128'(i), 0);
      step();
    end
    checks++; if (fifo_level !== LVL_W'(5) || overflow_sticky !== 1'b1) begin
      errors++; $display("FAIL rmid_pre got level=%0d ovf=%0b exp 5 1", fifo_level, overflow_sticky);
    end
    rst_wr_n = 1'b0;
    set_in(1, 1, 1, LPIF_ST_ACTIVE, 128'h777, 1);
    step();
    checks++; if ({pl_valid, fifo_level, credit_return, overflow_sticky, pl_state, pl_state_chg} !== '0) begin
      errors++; $display("FAIL rmid_reset got valid=%0b level=%0d credit=%0b ovf=%0b state=%h chg=%0b exp all 0",
                         pl_valid, fifo_level, credit_return, overflow_sticky, pl_state, pl_state_chg);
    end
    checks++; if (pl_data !== '0) begin errors++; $display("FAIL rmid_data got=%h exp=0", pl_data); end
    rst_wr_n = 1'b1;
    set_in(1, 1, 1, LPIF_ST_RESET, 128'h4242, 0);
    step();
    checks++; if (pl_valid !== 1'b1 || pl_data !== 128'h4242) begin
      errors++; $display("FAIL rmid_push got valid=%0b data=%h exp 1 4242", pl_valid, pl_data);
    end
    $display("reset_mid: level=%0d data=%h", fifo_level, pl_data);
  endtask

  initial begin
    test_reset();
    test_basic_order();
    test_full_push_pop();
    test_overflow();
    test_state();
    test_flush();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
